// File: rtl/reg_readout_ctrl_if.sv
// Request/response and register-bank signals of the read-only register readout controller.
// With REG_READOUT_PARITY_EN defined, the bundle also carries the dataPar response bit.
interface reg_readout_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 3
);
  logic              reqValid;
  logic [ADDR_W-1:0] reqAddr;
  logic              reqReady;
  logic [ADDR_W-1:0] regSel;
  logic              latchOut;
  logic              shiftEn;
  logic              shiftIn;
  logic [WORD_W-1:0] dataOut;
  logic              dataErr;
  logic              dataValid;
  logic              dataReady;
`ifdef REG_READOUT_PARITY_EN
  logic              dataPar;
`endif

  // master is the controller; slave is the decoder/register-bank side
  modport master (
    input  reqValid, reqAddr, shiftIn, dataReady,
`ifdef REG_READOUT_PARITY_EN
    output dataPar,
`endif
    output reqReady, regSel, latchOut, shiftEn, dataOut, dataErr, dataValid
  );

  modport slave (
    output reqValid, reqAddr, shiftIn, dataReady,
`ifdef REG_READOUT_PARITY_EN
    input  dataPar,
`endif
    input  reqReady, regSel, latchOut, shiftEn, dataOut, dataErr, dataValid
  );
endinterface

// File: rtl/reg_readout_ctrl.sv
// Reads a parallel-load shift register: latch strobe, WORD_W-cycle MSB-first shift, word response.
// Optional macro REG_READOUT_PARITY_EN adds a registered dataPar (XOR of dataOut).
module reg_readout_ctrl #(
  parameter int WORD_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                bclk,
  input  logic                rst,
  input  logic                clkEn,
  reg_readout_ctrl_if.master  bus
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, RESP} state_e;

  state_e              state_q;
  logic                reqReady_q;
  logic                latchOut_q;
  logic                shiftEn_q;
  logic                dataValid_q;
  logic                dataErr_q;
  logic [ADDR_W-1:0]   regSel_q;
  logic [WORD_W-1:0]   dataOut_q;
  logic [WORD_W-1:0]   capture_q;
  logic [WORD_W-1:0]   capture_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_range;
  logic                accept_err;
  logic                last_bit;

  function automatic logic word_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

  always_comb begin
    capture_d  = {capture_q[WORD_W-2:0], bus.shiftIn};
    in_range   = ({1'b0, bus.reqAddr} < NUM_REGS_L);
    accept_err = (state_q == IDLE) && reqReady_q && bus.reqValid && !in_range;
    last_bit   = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  end

  // Control FSM; every output is a register so the bank sees clean strobes
  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q     <= IDLE;
      reqReady_q  <= 1'b0;
      latchOut_q  <= 1'b0;
      shiftEn_q   <= 1'b0;
      dataValid_q <= 1'b0;
      dataErr_q   <= 1'b0;
      dataOut_q   <= '0;
      regSel_q    <= '0;
      cnt_q       <= '0;
    end else if (clkEn) begin
      unique case (state_q)
        IDLE: begin
          if (!reqReady_q) begin
            reqReady_q <= 1'b1;
          end else if (bus.reqValid) begin
            reqReady_q <= 1'b0;
            if (in_range) begin
              regSel_q   <= bus.reqAddr;
              latchOut_q <= 1'b1;
              state_q    <= LATCH;
            end else begin
              dataOut_q   <= '0;
              dataErr_q   <= 1'b1;
              dataValid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        LATCH: begin
          latchOut_q <= 1'b0;
          shiftEn_q  <= 1'b1;
          cnt_q      <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            shiftEn_q   <= 1'b0;
            dataOut_q   <= capture_d;
            dataErr_q   <= 1'b0;
            dataValid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.dataReady) begin
            dataValid_q <= 1'b0;
            reqReady_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Deserialiser holds no reset: a partial word is always overwritten before use
  always_ff @(posedge bclk) begin
    if (clkEn && (state_q == SHIFT)) begin
      capture_q <= capture_d;
    end
  end

`ifdef REG_READOUT_PARITY_EN
  logic dataPar_q;

  always_ff @(posedge bclk) begin
    if (rst) begin
      dataPar_q <= 1'b0;
    end else if (clkEn) begin
      if (last_bit) begin
        dataPar_q <= word_parity(capture_d);
      end else if (accept_err) begin
        dataPar_q <= 1'b0;
      end
    end
  end

  assign bus.dataPar = dataPar_q;
`else
  logic unused_par;
  assign unused_par = word_parity(capture_d) ^ accept_err;
`endif

  assign bus.reqReady  = reqReady_q;
  assign bus.regSel    = regSel_q;
  assign bus.latchOut  = latchOut_q;
  assign bus.shiftEn   = shiftEn_q;
  assign bus.dataOut   = dataOut_q;
  assign bus.dataErr   = dataErr_q;
  assign bus.dataValid = dataValid_q;

endmodule

// File: tb/tb_reg_readout_ctrl.sv
// Bench for reg_readout_ctrl: behavioural register bank plus per-read response/latency model.
module tb_reg_readout_ctrl;

  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 4;

  logic        bclk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b1;
  logic        junk = 1'b0;
  logic [31:0] sh = '0;
  logic [31:0] regs [NUM_REGS];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  reg_readout_ctrl_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  reg_readout_ctrl #(.WORD_W(WORD_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .bclk  (bclk),
    .rst   (rst),
    .clkEn (clkEn),
    .bus   (bus)
  );

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  // Register bank: parallel load on latchOut, shift left on shiftEn, MSB on shiftOut
  always @(posedge bclk) begin
    if (clkEn) begin
      if (bus.latchOut) sh <= regs[bus.regSel[2:0]];
      else if (bus.shiftEn) sh <= {sh[30:0], 1'b0};
    end
  end
  assign bus.shiftIn = bus.shiftEn ? sh[31] : junk;

  task automatic tick();
    @(posedge bclk);
    #1;
    junk = 1'($urandom);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [3:0] addr, input int stall_at, input int stall_len, input int hold);
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat, cycE, lc, sc, guard;
    bit          stalled, sel_ok, stable;
    exp_err  = (int'(addr) >= NUM_REGS);
    exp_data = exp_err ? 32'h0 : regs[addr[2:0]];
    exp_lat  = exp_err ? 1 : WORD_W + 2 + stall_len;
    guard = 0;
    while (bus.reqReady !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("req_ready_idle", 64'(bus.reqReady), 64'(1));
    bus.reqValid = 1'b1;
    bus.reqAddr  = addr;
    tick();
    cycE = cyc;
    bus.reqValid = 1'b0;
    bus.reqAddr  = 4'($urandom);
    lc = 0; sc = 0; stalled = 0; sel_ok = 1;
    while (bus.dataValid !== 1'b1 && (cyc - cycE) < 200) begin
      if (stall_len > 0 && !stalled && sc == stall_at) begin
        clkEn = 1'b0;
        repeat (stall_len) tick();
        clkEn = 1'b1;
        stalled = 1;
      end
      if (bus.latchOut === 1'b1) lc++;
      if (bus.shiftEn === 1'b1) sc++;
      if (!exp_err && bus.regSel !== addr) sel_ok = 0;
      tick();
    end
    chk("resp_valid", 64'(bus.dataValid), 64'(1));
    chk("resp_latency", 64'(cyc - cycE + 1), 64'(exp_lat));
    chk("latch_cycles", 64'(lc), 64'(exp_err ? 0 : 1));
    chk("shift_cycles", 64'(sc), 64'(exp_err ? 0 : WORD_W));
    chk("dataOut", 64'(bus.dataOut), 64'(exp_data));
    chk("dataErr", 64'(bus.dataErr), 64'(exp_err));
    chk("req_ready_busy", 64'(bus.reqReady), 64'(0));
    if (!exp_err) chk("regSel_held", 64'(sel_ok && (bus.regSel === addr)), 64'(1));
`ifdef REG_READOUT_PARITY_EN
    chk("dataPar", 64'(bus.dataPar), 64'(exp_err ? 0 : ($countones(exp_data) % 2)));
`endif
    stable = 1;
    repeat (hold) begin
      tick();
      if (bus.dataValid !== 1'b1 || bus.dataOut !== exp_data || bus.dataErr !== exp_err ||
          bus.reqReady !== 1'b0 || (!exp_err && bus.regSel !== addr)) stable = 0;
    end
    if (hold > 0) chk("resp_hold", 64'(stable), 64'(1));
    bus.dataReady = 1'b1;
    tick();
    bus.dataReady = 1'b0;
    chk("valid_drop", 64'(bus.dataValid), 64'(0));
    chk("ready_back", 64'(bus.reqReady), 64'(1));
  endtask

  initial begin
    int sc, guard;
    logic [3:0] a;
    bus.reqValid  = 1'b0;
    bus.reqAddr   = '0;
    bus.dataReady = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;

    // Reset applies even with clkEn low
    rst = 1'b1;
    clkEn = 1'b0;
    tick();
    tick();
    chk("rst_reqReady", 64'(bus.reqReady), 64'(0));
    chk("rst_latchOut", 64'(bus.latchOut), 64'(0));
    chk("rst_shiftEn", 64'(bus.shiftEn), 64'(0));
    chk("rst_dataValid", 64'(bus.dataValid), 64'(0));
    chk("rst_dataErr", 64'(bus.dataErr), 64'(0));
    chk("rst_dataOut", 64'(bus.dataOut), 64'(0));
    chk("rst_regSel", 64'(bus.regSel), 64'(0));
`ifdef REG_READOUT_PARITY_EN
    chk("rst_dataPar", 64'(bus.dataPar), 64'(0));
`endif
    clkEn = 1'b1;
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 64'(bus.reqReady), 64'(1));

    regs[2] = 32'hA5C3_0F81;
    do_read(4'd2, -1, 0, 0);
    regs[5] = 32'hFFFF_FFFF;
    do_read(4'd5, -1, 0, 10);
    do_read(4'd9, -1, 0, 2);
    regs[0] = 32'h8000_0001;
    do_read(4'd0, 10, 5, 0);

    // Reset in the middle of the shift phase
    regs[6] = $urandom;
    bus.reqValid = 1'b1;
    bus.reqAddr  = 4'd6;
    tick();
    bus.reqValid = 1'b0;
    sc = 0;
    guard = 0;
    while (sc < 20 && guard < 100) begin
      if (bus.shiftEn === 1'b1) sc++;
      guard++;
      tick();
    end
    chk("midrst_reached_shift", 64'(sc), 64'(20));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_latchOut", 64'(bus.latchOut), 64'(0));
    chk("midrst_shiftEn", 64'(bus.shiftEn), 64'(0));
    chk("midrst_dataValid", 64'(bus.dataValid), 64'(0));
    chk("midrst_reqReady", 64'(bus.reqReady), 64'(0));
    tick();
    chk("midrst_ready_after", 64'(bus.reqReady), 64'(1));
    chk("midrst_no_resp", 64'(bus.dataValid), 64'(0));
    regs[3] = 32'h1234_5678;
    do_read(4'd3, -1, 0, 0);

    regs[1] = 32'h0000_0007;
    do_read(4'd1, -1, 0, 0);
    regs[4] = 32'h0000_0003;
    do_read(4'd4, -1, 0, 1);

    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 15));
      if (int'(a) < NUM_REGS) regs[a[2:0]] = $urandom;
      do_read(a, (i % 3 == 0) ? int'($urandom_range(1, 30)) : -1,
              (i % 3 == 0) ? int'($urandom_range(1, 4)) : 0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_readout_ctrl.md
Name: reg_readout_ctrl

Overview:
- Initiator/receiver for the parallel-load read-only shift registers used in the register block.
- Accepts a register-read request and selects the target register. Pulses latchOut to load the register's shifter, then drives shiftEn for WORD_W cycles.
- Deserialises the MSB-first shiftOut stream back into a parallel word and returns it with a valid/ready handshake.
- Sits between the command decoder and the bank of read-only registers. The shiftOut lines of the bank are muxed externally by regSel onto shiftIn.

Parameters:
- WORD_W, 32, bits per register; the shift phase lasts exactly WORD_W cycles.
- NUM_REGS, 8, number of addressable read-only registers.
- ADDR_W, 3, width of reqAddr/regSel; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- bclk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clkEn  in  1  clock enable; when low, all state and outputs are frozen (reset excepted).
- reqValid  in  1  read request present.
- reqAddr  in  ADDR_W  register index to read.
- reqReady  out  1  controller can accept a request.
- regSel  out  ADDR_W  index of the register being read; drives the external shiftOut mux and latch/shift demux.
- latchOut  out  1  one-cycle load strobe to the selected register.
- shiftEn  out  1  shift enable to the selected register.
- shiftIn  in  1  muxed shiftOut of the selected register, MSB first.
- dataOut  out  WORD_W  captured word.
- dataErr  out  1  set with dataValid when reqAddr >= NUM_REGS.
- dataValid  out  1  response valid.
- dataReady  in  1  response consumer ready.
- dataPar  out  1  even parity of dataOut (only with the optional feature).

Behaviour:
- Reset takes effect on any bclk edge with rst=1, independent of clkEn.
- Reset values:
  - state=IDLE, reqReady=0 during reset, 1 the cycle after.
  - latchOut=0, shiftEn=0, dataValid=0, dataErr=0, dataOut=0, regSel=0, bit counter=0.
- All transitions occur only on edges with clkEn=1; with clkEn=0 every register holds and outputs keep their values.
- State IDLE:
  - reqReady=1.
  - On reqValid=1, the request is accepted.
  - If reqAddr < NUM_REGS: regSel<=reqAddr, next state LATCH.
  - Otherwise: dataOut<=0, dataErr<=1, next state RESP (no latch or shift issued).
- State LATCH:
  - reqReady=0, latchOut=1, shiftEn=0 for exactly one enabled cycle. Next state SHIFT, counter<=0.
- State SHIFT:
  - shiftEn=1, latchOut=0 for exactly WORD_W enabled cycles.
  - Each enabled edge: capture<={capture[WORD_W-2:0], shiftIn}, counter++.
  - On the edge where counter==WORD_W-1: dataOut<=final capture, dataErr<=0, next state RESP.
- State RESP:
  - dataValid=1; dataOut/dataErr stable.
  - On dataValid&dataReady the controller returns to IDLE and dataValid drops on the next cycle.
  - Back-to-back accept in the same cycle is not supported; reqReady is 1 only in IDLE.
- regSel is held constant from the accept edge through the end of RESP.
- Latency: accept edge E → latchOut high in cycle E+1 → shiftEn high in cycles E+2..E+WORD_W+1 → dataValid high in cycle E+WORD_W+2 (E+34 for default), assuming clkEn=1 throughout.
- clkEn low mid-SHIFT: no bit is captured and the counter does not advance; the captured word is unaffected.
- rst mid-operation: immediate return to IDLE; latchOut/shiftEn drop the next cycle. Any partial word is discarded and no response is issued.
- shiftIn is ignored outside SHIFT.

Optional Feature:
- Macro: REG_READOUT_PARITY_EN.
- Defined:
  - dataPar = XOR-reduction of dataOut, registered together with dataOut.
  - dataPar is 0 on reset and 0 for error responses.
- Undefined:
  - dataPar port is absent; no parity logic is instantiated.

Test Plan:
- Reset, then request addr 2 with the register holding 0xA5C3_0F81 → latchOut pulse 1 cycle after accept, shiftEn for 32 cycles, dataValid at E+34 with dataOut=0xA5C3_0F81, dataErr=0, regSel=2 throughout.
- Request addr 5 (0xFFFF_FFFF), dataReady held low 10 cycles → dataValid stays 1, dataOut stable for 10 cycles; reqReady=0 until handshake, then 1.
- Request addr 9 with NUM_REGS=8 (ADDR_W=4) → no latchOut/shiftEn, dataValid next cycle, dataOut=0, dataErr=1.
- clkEn low for 5 cycles after shift bit 10, register 0x8000_0001 → dataOut=0x8000_0001, dataValid delayed to E+39.
- rst asserted during shift bit 20 → latchOut/shiftEn=0 and dataValid=0 the next cycle, reqReady=1 after reset. A new read of 0x1234_5678 then returns the correct value.
- With REG_READOUT_PARITY_EN: read 0x0000_0007 → dataPar=1; read 0x0000_0003 → dataPar=0.
